// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: drives the PC register, issues one imem read per
// instruction, holds the result for the decoder and handles branch redirects.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  output logic [31:0] pc_next,
  output logic        pc_ld,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic [31:0] ir,
  output logic [31:0] ir_pc,
  output logic        ir_valid,
  input  logic        ir_ready,
  input  logic        br_taken,
  input  logic [31:0] br_target
);

  typedef enum logic [1:0] {S_LOAD, S_REQ, S_HOLD} state_t;

  state_t      r_state,    w_state_nxt;
  logic [31:0] r_target,   w_target_nxt;
  logic        r_drop,     w_drop_nxt;
  logic [31:0] r_ir,       w_ir_nxt;
  logic [31:0] r_ir_pc,    w_ir_pc_nxt;
  logic        r_ir_valid, w_ir_valid_nxt;
  logic [31:0] w_pc_inc;

  assign w_pc_inc  = pc + 32'(PC_STEP);
  assign pc_next   = r_target;
  assign imem_addr = pc;
  assign ir        = r_ir;
  assign ir_pc     = r_ir_pc;
  assign ir_valid  = r_ir_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_LOAD;
      r_target   <= RESET_PC;
      r_drop     <= 1'b0;
      r_ir       <= '0;
      r_ir_pc    <= '0;
      r_ir_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_target   <= w_target_nxt;
      r_drop     <= w_drop_nxt;
      r_ir       <= w_ir_nxt;
      r_ir_pc    <= w_ir_pc_nxt;
      r_ir_valid <= w_ir_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_target_nxt   = r_target;
    w_drop_nxt     = r_drop;
    w_ir_nxt       = r_ir;
    w_ir_pc_nxt    = r_ir_pc;
    w_ir_valid_nxt = r_ir_valid;
    pc_ld          = 1'b0;
    imem_req       = 1'b0;
    case (r_state)
      S_LOAD: begin
        pc_ld = 1'b1;
        // A redirect here repeats LOAD so the PC register picks up the new target.
        if (br_taken) w_target_nxt = br_target;
        else          w_state_nxt  = S_REQ;
      end
      S_REQ: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          w_state_nxt = S_LOAD;
          w_drop_nxt  = 1'b0;
          if (br_taken) begin
            w_target_nxt = br_target;
          end else if (!r_drop) begin
            w_ir_nxt       = imem_data;
            w_ir_pc_nxt    = pc;
            w_ir_valid_nxt = 1'b1;
            w_target_nxt   = w_pc_inc;
            w_state_nxt    = S_HOLD;
          end
        end else if (br_taken) begin
          // Request already in flight: let it finish, then throw its data away.
          w_target_nxt = br_target;
          w_drop_nxt   = 1'b1;
        end
      end
      S_HOLD: begin
        if (br_taken) begin
          w_ir_valid_nxt = 1'b0;
          w_target_nxt   = br_target;
          w_state_nxt    = S_LOAD;
        end else if (ir_ready) begin
          w_ir_valid_nxt = 1'b0;
          w_state_nxt    = S_LOAD;
        end
      end
      default: w_state_nxt = S_LOAD;
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: PC register and imem responder models,
// scoreboard of expected fetch addresses checked on each decoder accept.
module tb_fetch_unit;
  localparam logic [31:0] KEY  = 32'h5A5A_0F0F;
  localparam logic [31:0] NONE = 32'h0000_0001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc, pc_next, imem_addr, imem_data, ir, ir_pc, br_target;
  logic        pc_ld, imem_req, imem_ack, ir_valid, ir_ready, br_taken;
  logic        mem_ack, late_ack;
  logic [31:0] mem_data;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_e;
  logic [31:0] slow_addr;
  int          slow_lat, cnt, lat;
  bit          dbeef;

  always #5 clk = ~clk;

  assign imem_ack  = mem_ack | late_ack;
  assign imem_data = mem_data;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .pc_next(pc_next), .pc_ld(pc_ld),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_data(imem_data), .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid),
    .ir_ready(ir_ready), .br_taken(br_taken), .br_target(br_target)
  );

  // PC register; resets to junk so the first LOAD is observable
  always @(posedge clk or negedge rst_n)
    if (!rst_n)     pc <= 32'hCAFE_0000;
    else if (pc_ld) pc <= pc_next;

  // imem responder: ack after 'lat' wait cycles, data = addr ^ KEY
  always @(negedge clk) begin
    if (!rst_n || !imem_req) begin
      mem_ack = 1'b0;
      cnt     = 0;
    end else begin
      lat = (imem_addr == slow_addr) ? slow_lat : 0;
      if (cnt >= lat) begin
        mem_ack  = 1'b1;
        mem_data = (dbeef && imem_addr == slow_addr) ? 32'hDEAD_BEEF : (imem_addr ^ KEY);
        cnt      = 0;
      end else begin
        mem_ack = 1'b0;
        cnt++;
      end
    end
  end

  // Scoreboard: every decoder accept must match the next expected address
  always @(negedge clk) begin
    if (rst_n && ir_valid && ir_ready && !br_taken) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL accept: unexpected instruction ir_pc=%h ir=%h", ir_pc, ir);
      end else begin
        mon_e = exp_q.pop_front();
        if (ir_pc !== mon_e || ir !== (mon_e ^ KEY)) begin
          errors++;
          $display("FAIL accept: ir_pc=%h ir=%h, want ir_pc=%h ir=%h", ir_pc, ir, mon_e, mon_e ^ KEY);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ir_ready = 1'b0; br_taken = 1'b0; late_ack = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_drain(output bit ok);
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    ok = (exp_q.size() == 0);
  endtask

  task automatic test_sequential();
    logic [2:0] exp_v;
    do_reset();
    ir_ready = 1'b1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    for (int k = 1; k <= 9; k++) begin
      tick();
      exp_v = {k % 3 == 0, k % 3 == 1, k % 3 == 2};
      checks++;
      if ({pc_ld, imem_req, ir_valid} !== exp_v) begin
        errors++;
        $display("FAIL seq_ctrl k=%0d: {pc_ld,req,valid}=%b want %b", k, {pc_ld, imem_req, ir_valid}, exp_v);
      end
      if (exp_v[1]) begin
        checks++;
        if (imem_addr !== 32'(4 * (k / 3))) begin
          errors++;
          $display("FAIL seq_addr k=%0d: imem_addr=%h want %h", k, imem_addr, 4 * (k / 3));
        end
      end
    end
    ir_ready = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL seq_drain: %0d fetches missing, want 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({pc_ld, imem_req, ir_valid} !== 3'b100 || ir !== 32'h0 || ir_pc !== 32'h0 || pc_next !== 32'h0) begin
      errors++;
      $display("FAIL reset_vals: pc_ld=%b req=%b valid=%b ir=%h ir_pc=%h pc_next=%h, want 1 0 0 0 0 0",
               pc_ld, imem_req, ir_valid, ir, ir_pc, pc_next);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    checks++;
    if (pc_ld !== 1'b1 || pc_next !== 32'h0) begin
      errors++;
      $display("FAIL reset_first: pc_ld=%b pc_next=%h, want 1 00000000", pc_ld, pc_next);
    end
    tick();
    checks++;
    if (pc !== 32'h0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_load: pc=%h req=%b addr=%h, want 00000000 1 00000000", pc, imem_req, imem_addr);
    end
  endtask

  task automatic test_ack_delay();
    int n8 = 0;
    do_reset();
    slow_addr = 32'h8; slow_lat = 3; ir_ready = 1'b1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      tick();
      if (imem_req && imem_addr == 32'h8) n8++;
    end
    ir_ready = 1'b0; slow_addr = NONE;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL delay_drain: %0d fetches missing, want 0", exp_q.size());
    end
    checks++;
    if (n8 != 4) begin
      errors++;
      $display("FAIL delay_hold: req at 8 for %0d cycles, want 4", n8);
    end
  endtask

  task automatic test_stall();
    do_reset();
    exp_q.push_back(32'h0);
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (ir_valid !== 1'b1 || ir !== (32'h0 ^ KEY) || ir_pc !== 32'h0 || pc_ld !== 1'b0 || imem_req !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold i=%0d: valid=%b ir=%h ir_pc=%h pc_ld=%b req=%b, want 1 %h 0 0 0",
                 i, ir_valid, ir, ir_pc, pc_ld, imem_req, KEY);
      end
      tick();
    end
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    checks++;
    if (pc_ld !== 1'b1 || pc_next !== 32'h4 || ir_valid !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL stall_release: pc_ld=%b pc_next=%h valid=%b pending=%0d, want 1 4 0 0",
               pc_ld, pc_next, ir_valid, exp_q.size());
    end
  endtask

  task automatic test_br_hold();
    bit ok;
    do_reset();
    ir_ready = 1'b1;
    tick(); tick();
    checks++;
    if (ir_valid !== 1'b1) begin
      errors++;
      $display("FAIL brh_pre: ir_valid=%b want 1", ir_valid);
    end
    br_taken = 1'b1; br_target = 32'h100;
    tick();
    br_taken = 1'b0;
    checks++;
    if (ir_valid !== 1'b0 || pc_ld !== 1'b1 || pc_next !== 32'h100) begin
      errors++;
      $display("FAIL brh_load: valid=%b pc_ld=%b pc_next=%h, want 0 1 00000100", ir_valid, pc_ld, pc_next);
    end
    exp_q.push_back(32'h100);
    tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      errors++;
      $display("FAIL brh_fetch: req=%b addr=%h, want 1 00000100", imem_req, imem_addr);
    end
    wait_drain(ok);
    ir_ready = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL brh_drain: timeout, %0d pending want 0", exp_q.size());
    end
  endtask

  task automatic test_br_req();
    bit ok;
    do_reset();
    slow_addr = 32'h0; slow_lat = 2; dbeef = 1'b1; ir_ready = 1'b1;
    tick();
    br_taken = 1'b1; br_target = 32'h180;
    tick();
    br_target = 32'h200;
    tick();
    br_taken = 1'b0;
    checks++;
    if (ir_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL brr_wait: valid=%b req=%b addr=%h, want 0 1 00000000", ir_valid, imem_req, imem_addr);
    end
    tick();
    checks++;
    if (ir_valid !== 1'b0 || pc_ld !== 1'b1 || pc_next !== 32'h200) begin
      errors++;
      $display("FAIL brr_load: valid=%b pc_ld=%b pc_next=%h, want 0 1 00000200", ir_valid, pc_ld, pc_next);
    end
    exp_q.push_back(32'h200);
    tick();
    checks++;
    if (ir_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      errors++;
      $display("FAIL brr_fetch: valid=%b req=%b addr=%h, want 0 1 00000200", ir_valid, imem_req, imem_addr);
    end
    wait_drain(ok);
    ir_ready = 1'b0; dbeef = 1'b0; slow_addr = NONE;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL brr_drain: timeout, %0d pending want 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    slow_addr = 32'h0; slow_lat = 5; ir_ready = 1'b1;
    tick(); tick();
    checks++;
    if (imem_req !== 1'b1) begin
      errors++;
      $display("FAIL rmid_pre: req=%b want 1", imem_req);
    end
    #2 rst_n = 1'b0; late_ack = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0 || pc_ld !== 1'b1) begin
      errors++;
      $display("FAIL rmid_async: req=%b pc_ld=%b, want 0 1", imem_req, pc_ld);
    end
    slow_addr = NONE;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    checks++;
    if (pc_ld !== 1'b1 || pc_next !== 32'h0) begin
      errors++;
      $display("FAIL rmid_load: pc_ld=%b pc_next=%h, want 1 00000000", pc_ld, pc_next);
    end
    tick();
    late_ack = 1'b0;
    checks++;
    if (ir_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL rmid_restart: valid=%b req=%b addr=%h, want 0 1 00000000", ir_valid, imem_req, imem_addr);
    end
    exp_q.push_back(32'h0);
    wait_drain(ok);
    ir_ready = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rmid_drain: timeout, %0d pending want 0", exp_q.size());
    end
  endtask

  task automatic test_wrap();
    bit ok;
    do_reset();
    ir_ready = 1'b1; br_taken = 1'b1; br_target = 32'hFFFF_FFFC;
    tick();
    br_taken = 1'b0;
    checks++;
    if (pc_ld !== 1'b1 || imem_req !== 1'b0 || pc_next !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_reload: pc_ld=%b req=%b pc_next=%h, want 1 0 fffffffc", pc_ld, imem_req, pc_next);
    end
    exp_q.push_back(32'hFFFF_FFFC);
    tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_fetch: req=%b addr=%h, want 1 fffffffc", imem_req, imem_addr);
    end
    tick();
    checks++;
    if (ir_valid !== 1'b1 || pc_next !== 32'h0) begin
      errors++;
      $display("FAIL wrap_next: valid=%b pc_next=%h, want 1 00000000", ir_valid, pc_next);
    end
    tick();
    checks++;
    if (pc_ld !== 1'b1 || pc_next !== 32'h0) begin
      errors++;
      $display("FAIL wrap_load: pc_ld=%b pc_next=%h, want 1 00000000", pc_ld, pc_next);
    end
    exp_q.push_back(32'h0);
    wait_drain(ok);
    ir_ready = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wrap_drain: timeout, %0d pending want 0", exp_q.size());
    end
  endtask

  initial begin
    rst_n = 1'b0; ir_ready = 1'b0; br_taken = 1'b0; br_target = '0;
    late_ack = 1'b0; slow_addr = NONE; slow_lat = 0; dbeef = 1'b0;
    test_sequential();
    test_reset();
    test_ack_delay();
    test_stall();
    test_br_hold();
    test_br_req();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
